// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller and its passive monitor.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    RED     = 2'b10,
    ILLEGAL = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    F_NONE      = 3'd0,
    F_ILLEGAL   = 3'd1,
    F_CONFLICT  = 3'd2,
    F_BAD_SEQ   = 3'd3,
    F_YEL_SHORT = 3'd4,
    F_YEL_LONG  = 3'd5
  } fault_t;

  typedef enum logic [1:0] {
    T_UNKNOWN,
    T_GREEN,
    T_YELLOW,
    T_RED
  } tracker_t;

  // An illegal lamp code leaves the tracker with no trusted history.
  function automatic tracker_t to_tracker(input light_t l);
    case (l)
      GREEN:   return T_GREEN;
      YELLOW:  return T_YELLOW;
      RED:     return T_RED;
      default: return T_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/light_seq_checker.sv
// Per-street colour tracker: sequence and yellow-duration flags plus a
// saturating count of completed red->green phases.
module light_seq_checker
  import traffic_pkg::*;
#(
  parameter int YELLOW_MIN = 1,
  parameter int YELLOW_MAX = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  light_t           light,
  output logic             bad_seq,
  output logic             yel_short,
  output logic             yel_long,
  output logic [CNT_W-1:0] phases
);

  localparam int YTOP = (YELLOW_MIN > YELLOW_MAX + 1) ? YELLOW_MIN : YELLOW_MAX + 1;
  localparam int YW   = $clog2(YTOP + 1);
  localparam logic [YW-1:0] YCNT_SAT = YW'(YELLOW_MAX + 1);
  localparam logic [YW-1:0] YCNT_MIN = YW'(YELLOW_MIN);

  tracker_t       state;
  logic [YW-1:0]  ycnt;
  logic [YW-1:0]  ycnt_next;
  logic           seen;
  logic           phase_inc;

  // Flags only fire once the tracker holds a known colour and the sample is legal.
  always_comb begin
    seen      = (state != T_UNKNOWN) && (light != ILLEGAL);
    ycnt_next = '0;
    bad_seq   = 1'b0;
    yel_short = 1'b0;
    yel_long  = 1'b0;
    phase_inc = 1'b0;
    if (light == YELLOW)
      ycnt_next = (ycnt == YCNT_SAT) ? ycnt : ycnt + 1'b1;
    if (seen) begin
      case (state)
        T_GREEN:  bad_seq = (light == RED);
        T_YELLOW: begin
          bad_seq   = (light == GREEN);
          yel_short = (light == RED) && (ycnt < YCNT_MIN);
        end
        T_RED: begin
          bad_seq   = (light == YELLOW);
          phase_inc = (light == GREEN);
        end
        default: ;
      endcase
      yel_long = (light == YELLOW) && (ycnt_next == YCNT_SAT) && (ycnt != YCNT_SAT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= T_UNKNOWN;
      ycnt   <= '0;
      phases <= '0;
    end else if (clear) begin
      state <= T_UNKNOWN;
      ycnt  <= '0;
    end else begin
      state <= to_tracker(light);
      ycnt  <= ycnt_next;
      if (phase_inc && (phases != '1))
        phases <= phases + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive monitor for the two-street controller: latches the first
// violation with a code and street, and counts completed green phases.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int YELLOW_MIN = 1,
  parameter int YELLOW_MAX = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       lA,
  input  logic [1:0]       lB,
  input  logic             clear,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             fault_street,
  output logic [CNT_W-1:0] phasesA,
  output logic [CNT_W-1:0] phasesB
);

  light_t light_a;
  light_t light_b;
  logic   bad_a, short_a, long_a;
  logic   bad_b, short_b, long_b;
  fault_t new_code;
  logic   new_street;
  fault_t code_q;

  assign light_a = light_t'(lA);
  assign light_b = light_t'(lB);

  light_seq_checker #(
    .YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX), .CNT_W(CNT_W)
  ) u_chk_a (
    .clk(clk), .reset(reset), .clear(clear), .light(light_a),
    .bad_seq(bad_a), .yel_short(short_a), .yel_long(long_a), .phases(phasesA)
  );

  light_seq_checker #(
    .YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX), .CNT_W(CNT_W)
  ) u_chk_b (
    .clk(clk), .reset(reset), .clear(clear), .light(light_b),
    .bad_seq(bad_b), .yel_short(short_b), .yel_long(long_b), .phases(phasesB)
  );

  // Lowest code wins; for equal codes street A is reported.
  always_comb begin
    new_code   = F_NONE;
    new_street = 1'b0;
    if (light_a == ILLEGAL) begin
      new_code = F_ILLEGAL;
    end else if (light_b == ILLEGAL) begin
      new_code   = F_ILLEGAL;
      new_street = 1'b1;
    end else if ((light_a != RED) && (light_b != RED)) begin
      new_code = F_CONFLICT;
    end else if (bad_a) begin
      new_code = F_BAD_SEQ;
    end else if (bad_b) begin
      new_code   = F_BAD_SEQ;
      new_street = 1'b1;
    end else if (short_a) begin
      new_code = F_YEL_SHORT;
    end else if (short_b) begin
      new_code   = F_YEL_SHORT;
      new_street = 1'b1;
    end else if (long_a) begin
      new_code = F_YEL_LONG;
    end else if (long_b) begin
      new_code   = F_YEL_LONG;
      new_street = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      fault        <= 1'b0;
      code_q       <= F_NONE;
      fault_street <= 1'b0;
    end else if (!fault && (new_code != F_NONE)) begin
      fault        <= 1'b1;
      code_q       <= new_code;
      fault_street <= new_street;
    end
  end

  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed plan steps then random walks, two monitor configurations in
// parallel, each compared every cycle against a rule-level reference model.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [1:0] lA;
  logic [1:0] lB;

  logic       fault_o  [2];
  logic [2:0] code_o   [2];
  logic       street_o [2];
  logic [7:0] pa_o     [2];
  logic [7:0] pb_o     [2];

  int tests = 0;
  int fails = 0;

  int ymin [2] = '{1, 2};
  int ymax [2] = '{1, 3};

  // Colours as ints: 0 green, 1 yellow, 2 red, 3 illegal / unknown history.
  int m_fault  [2];
  int m_code   [2];
  int m_street [2];
  int m_pa     [2];
  int m_pb     [2];
  int m_prev   [2][2];
  int m_ycnt   [2][2];

  always #5 clk = ~clk;

  traffic_light_monitor #(.YELLOW_MIN(1), .YELLOW_MAX(1), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .lA(lA), .lB(lB), .clear(clear),
    .fault(fault_o[0]), .fault_code(code_o[0]), .fault_street(street_o[0]),
    .phasesA(pa_o[0]), .phasesB(pb_o[0])
  );

  traffic_light_monitor #(.YELLOW_MIN(2), .YELLOW_MAX(3), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .lA(lA), .lB(lB), .clear(clear),
    .fault(fault_o[1]), .fault_code(code_o[1]), .fault_street(street_o[1]),
    .phasesA(pa_o[1]), .phasesB(pb_o[1])
  );

  function automatic int street_viol(input int d, input int s, input int lt);
    int p;
    int y;
    int ny;
    p = m_prev[d][s];
    y = m_ycnt[d][s];
    if (p == 3 || lt == 3) return 0;
    if (lt != p && lt != (p + 1) % 3) return 3;
    if (p == 1 && lt == 2 && y < ymin[d]) return 4;
    ny = (y + 1 > ymax[d] + 1) ? ymax[d] + 1 : y + 1;
    if (lt == 1 && ny == ymax[d] + 1 && y != ymax[d] + 1) return 5;
    return 0;
  endfunction

  task automatic model_step(input int a, input int b, input int clr, input int rst);
    int lt [2];
    int v  [2];
    int code;
    int st;
    lt[0] = a;
    lt[1] = b;
    for (int d = 0; d < 2; d++) begin
      if (rst != 0) begin
        m_fault[d] = 0; m_code[d] = 0; m_street[d] = 0;
        m_pa[d] = 0; m_pb[d] = 0;
        for (int s = 0; s < 2; s++) begin m_prev[d][s] = 3; m_ycnt[d][s] = 0; end
      end else if (clr != 0) begin
        m_fault[d] = 0; m_code[d] = 0; m_street[d] = 0;
        for (int s = 0; s < 2; s++) begin m_prev[d][s] = 3; m_ycnt[d][s] = 0; end
      end else begin
        code = 0;
        st   = 0;
        for (int s = 0; s < 2; s++) v[s] = street_viol(d, s, lt[s]);
        if (a == 3) code = 1;
        else if (b == 3) begin code = 1; st = 1; end
        else if (a != 2 && b != 2) code = 2;
        else
          for (int c = 3; c <= 5; c++)
            for (int s = 0; s < 2; s++)
              if (code == 0 && v[s] == c) begin code = c; st = s; end
        if (m_fault[d] == 0 && code != 0) begin
          m_fault[d] = 1; m_code[d] = code; m_street[d] = st;
        end
        if (m_prev[d][0] == 2 && a == 0 && m_pa[d] < 255) m_pa[d]++;
        if (m_prev[d][1] == 2 && b == 0 && m_pb[d] < 255) m_pb[d]++;
        for (int s = 0; s < 2; s++) begin
          if (lt[s] == 1)
            m_ycnt[d][s] = (m_ycnt[d][s] + 1 > ymax[d] + 1) ? ymax[d] + 1 : m_ycnt[d][s] + 1;
          else
            m_ycnt[d][s] = 0;
          m_prev[d][s] = lt[s];
        end
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int a, input int b, input int clr, input int rst);
    @(negedge clk);
    lA    = 2'(a);
    lB    = 2'(b);
    clear = (clr != 0);
    reset = (rst != 0);
    @(posedge clk);
    model_step(a, b, clr, rst);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("d%0d_fault", d),  32'(fault_o[d]),  m_fault[d]);
      check_output($sformatf("d%0d_code", d),   32'(code_o[d]),   m_code[d]);
      check_output($sformatf("d%0d_street", d), 32'(street_o[d]), m_street[d]);
      check_output($sformatf("d%0d_phasesA", d), 32'(pa_o[d]),    m_pa[d]);
      check_output($sformatf("d%0d_phasesB", d), 32'(pb_o[d]),    m_pb[d]);
    end
  endtask

  int seq_a [7] = '{0, 0, 1, 2, 2, 2, 0};
  int seq_b [7] = '{2, 2, 2, 0, 1, 2, 2};
  int cur   [2];
  int drv   [2];
  int r;
  int q;

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    lA    = 2'd2;
    lB    = 2'd2;

    apply_stimulus(2, 2, 0, 1);
    check_output("reset_fault", 32'(fault_o[0]), 0);
    check_output("reset_phasesA", 32'(pa_o[0]), 0);

    for (int i = 0; i < 7; i++) apply_stimulus(seq_a[i], seq_b[i], 0, 0);
    check_output("plan_cycle_fault", 32'(fault_o[0]), 0);
    check_output("plan_cycle_phasesA", 32'(pa_o[0]), 1);
    check_output("plan_cycle_phasesB", 32'(pb_o[0]), 1);

    apply_stimulus(2, 2, 1, 0);
    apply_stimulus(3, 2, 0, 0);
    check_output("plan_illegal_code", 32'(code_o[0]), 1);
    check_output("plan_illegal_street", 32'(street_o[0]), 0);
    apply_stimulus(2, 0, 0, 0);
    apply_stimulus(2, 2, 0, 0);
    check_output("plan_illegal_frozen", 32'(code_o[0]), 1);

    apply_stimulus(2, 2, 1, 0);
    check_output("plan_clear_fault", 32'(fault_o[0]), 0);
    check_output("plan_clear_phasesA", 32'(pa_o[0]), 1);
    apply_stimulus(0, 0, 0, 0);
    check_output("plan_conflict_code", 32'(code_o[0]), 2);

    apply_stimulus(2, 2, 1, 0);
    apply_stimulus(0, 2, 0, 0);
    apply_stimulus(2, 2, 0, 0);
    check_output("plan_badseq_code", 32'(code_o[0]), 3);

    apply_stimulus(2, 2, 1, 0);
    apply_stimulus(2, 0, 0, 0);
    apply_stimulus(2, 1, 0, 0);
    apply_stimulus(2, 1, 0, 0);
    check_output("plan_yel_long_code", 32'(code_o[0]), 5);
    check_output("plan_yel_long_street", 32'(street_o[0]), 1);
    check_output("plan_yel_long_max3", 32'(fault_o[1]), 0);

    apply_stimulus(2, 0, 1, 0);
    apply_stimulus(2, 0, 0, 0);
    check_output("plan_unknown_start", 32'(fault_o[0]), 0);

    apply_stimulus(0, 2, 0, 0);
    apply_stimulus(1, 2, 0, 0);
    apply_stimulus(1, 2, 0, 1);
    check_output("plan_reset_mid_yellow_fault", 32'(fault_o[0]), 0);
    check_output("plan_reset_mid_yellow_phasesB", 32'(pb_o[0]), 0);

    cur[0] = 2;
    cur[1] = 2;
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < 2; s++) begin
        q = $urandom_range(0, 99);
        if (q < 55) drv[s] = cur[s];
        else if (q < 90) drv[s] = (cur[s] + 1) % 3;
        else if (q < 97) drv[s] = $urandom_range(0, 2);
        else drv[s] = 3;
        if (drv[s] != 3) cur[s] = drv[s];
      end
      r = $urandom_range(0, 99);
      apply_stimulus(drv[0], drv[1], (r >= 2 && r < 8) ? 1 : 0, (r < 2) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the light outputs of the traffic light controller (`fsm`). It samples both 2-bit light buses every clock and checks each street's colour sequence, yellow duration and cross-street safety. It latches the first violation as a sticky fault with a code, and counts completed green phases per street. It sits beside the controller in simulation and on the board, with `lA`/`lB` wired in parallel to the lamp drivers.

## Interface
- `YELLOW_MIN`, default 1: minimum cycles a street must hold yellow.
- `YELLOW_MAX`, default 1: maximum cycles a street may hold yellow.
- `CNT_W`, default 8: width of the phase counters.
- `clk` in 1: single clock; everything samples on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `lA` in 2: street A light; GREEN=2'b00, YELLOW=2'b01, RED=2'b10, 2'b11 illegal.
- `lB` in 2: street B light; same encoding.
- `clear` in 1: synchronous fault clear; counters are kept.
- `fault` out 1: sticky, set on the first violation.
- `fault_code` out 3: code of the first violation; 0 while `fault`=0.
- `fault_street` out 1: 0 = street A, 1 = street B; 0 for CONFLICT.
- `phasesA` out CNT_W: completed A phases, saturating.
- `phasesB` out CNT_W: completed B phases, saturating.

## Operation
- Per-street tracker state: UNKNOWN (after reset or clear), GREEN, YELLOW, RED. Each sample moves the tracker to the sampled colour.
- Legal transitions: same colour held; G->Y; Y->R; R->G; UNKNOWN->any legal colour.
- Fault codes, highest priority first:
  - 1 ILLEGAL: either bus is 2'b11. Tracker goes UNKNOWN.
  - 2 CONFLICT: neither street is RED in the same sample, illegal codes excluded.
  - 3 BAD_SEQ: any transition not listed as legal, e.g. G->R, Y->G, R->Y.
  - 4 YEL_SHORT: Y->R with yellow count < YELLOW_MIN.
  - 5 YEL_LONG: yellow count reaches YELLOW_MAX+1.
- Yellow count per street: set to 1 on entry to yellow, +1 per further yellow sample, saturates at YELLOW_MAX+1. YEL_LONG is flagged once, on the sample that reaches YELLOW_MAX+1.
- Simultaneous violations, same sample: the lowest code wins. For equal codes on both streets, street A wins.
- Once `fault`=1, `fault_code` and `fault_street` freeze. Checking and counting continue.
- Phase counter: +1 on each R->G transition of that street. A transition out of UNKNOWN never counts. Holds at all-ones.
- `clear`:
  - zeroes `fault`, `fault_code` and `fault_street`;
  - forces both trackers to UNKNOWN;
  - leaves phase counters unchanged;
  - no violation is checked on the `clear` edge.
- `reset` has priority over `clear`.

## Timing
- Reset values: `fault`=0, `fault_code`=0, `fault_street`=0, `phasesA`=0, `phasesB`=0, trackers UNKNOWN, yellow counts 0.
- Latency: values sampled at edge k are checked against the tracker state; `fault` and the counters show the result after edge k, i.e. one cycle later.
- First sample after reset or clear: only ILLEGAL and CONFLICT are checked; there are no sequence or yellow checks.
- Reset asserted mid-yellow or mid-fault: all state is discarded in the same edge. No partial counts survive.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `traffic_pkg` holds:
  - `light_t` enum: GREEN, YELLOW, RED, ILLEGAL with the encodings above;
  - `fault_t` enum: codes 0-5;
  - `tracker_t` enum.
- The controller should also import `light_t` from `traffic_pkg`.
- Sub-module `light_seq_checker`, instantiated once per street, contains:
  - the tracker FSM;
  - the yellow counter;
  - the phase counter;
  - per-street violation flags for codes 3-5.
- The top level owns the ILLEGAL and CONFLICT checks, the priority encoder and the sticky fault registers.

## Test plan
- Reset, then the normal controller cycle from reset: A G,G,Y,R,R,R,G with B R,R,R,G,Y,R,R -> `fault`=0; `phasesA`=1, `phasesB`=1 after the last A R->G.
- `lA`=2'b11 on one sample -> `fault`=1, `fault_code`=1, `fault_street`=0 one cycle later. A following B G->R skip does not change the code.
- A=G and B=G in the same sample -> `fault_code`=2, `fault_street`=0.
- A sequence G->R directly -> `fault_code`=3, `fault_street`=0.
- With YELLOW_MAX=1, B holds Y for 2 samples -> `fault_code`=5, `fault_street`=1 after the second yellow sample.
- Fault set, then pulse `clear` -> `fault`=0, counters unchanged. Next sample starts the tracker from UNKNOWN, so a Y->G is not flagged; reset mid-yellow zeroes all outputs.
